axis_8_bit_packet_tx: RTL and testbench
=======================================

Name: axis_8_bit_packet_tx

Overview:
- AXI-Stream style 8-bit packet transmitter; source side of the team's 8-bit T_valid/T_ready/Tlast stream.
- Local logic writes bytes sequentially into an internal buffer, then pulses start.
- The block then emits the buffered bytes as one packet, asserting Tlast on the final beat and holding the beat stable under backpressure.
- Output feeds any 8-bit stream sink in the design.

Parameters:
DEPTH, 16, buffer capacity in bytes (maximum packet length); must be >= 1
CNT_W, 5, width of byte counter; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write one byte into buffer (honoured in IDLE only)
wr_data  input  8  byte to buffer
wr_full  output  1  high when buffer holds DEPTH bytes
byte_count  output  CNT_W  number of bytes currently buffered
start  input  1  single-cycle request to transmit buffered packet
busy  output  1  high while in SEND
done  output  1  one-cycle pulse after final beat accepted
T_valid_out  output  1  stream valid
T_ready  input  1  stream ready from sink
Tlast  output  1  marks final beat of packet
out_data  output  8  stream data

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset takes priority over all other inputs.
- Reset values: state=IDLE, wr_ptr=0, rd_ptr=0, byte_count=0, wr_full=0, busy=0, done=0, T_valid_out=0, Tlast=0, out_data=8'h00.
- Output timing: all outputs are registered. byte_count = wr_ptr. wr_full = (wr_ptr == DEPTH).
- FSM: two states, IDLE and SEND.
- IDLE, write: wr_en=1 and !wr_full -> mem[wr_ptr] <= wr_data; wr_ptr++. wr_en while full is ignored (no wrap, no overwrite).
- IDLE, start:
  - start=1 and wr_ptr>0 -> latch len=wr_ptr; go to SEND.
  - Next cycle: T_valid_out=1, out_data=mem[0], Tlast=(len==1), busy=1. Latency start->first valid = 1 cycle.
- IDLE, start with empty buffer: start=1 and wr_ptr==0 -> ignored; no busy, no done.
- IDLE, start and wr_en together: start wins; the write is dropped and len = pre-existing wr_ptr.
- SEND, handshake: a beat transfers when T_valid_out && T_ready on a rising edge.
  - Transfer with Tlast=0: rd_ptr++; out_data=mem[rd_ptr+1]; Tlast=(rd_ptr+2 == len).
  - Transfer with Tlast=1: go to IDLE; T_valid_out=0, Tlast=0, out_data=0, busy=0, wr_ptr=0, rd_ptr=0, done=1 for exactly one cycle.
- SEND, backpressure: T_ready=0 -> T_valid_out, out_data and Tlast hold unchanged.
- SEND, valid rules:
  - T_valid_out never deasserts mid-packet.
  - Valid does not wait for ready.
  - Ready may be asserted before valid without effect.
- SEND, throughput: one beat per cycle while T_ready=1. Back-to-back packets need >= 1 IDLE cycle to load, plus the start cycle.
- SEND, ignored inputs: start and wr_en are ignored; buffer contents are frozen.
- Reset mid-packet: next cycle returns all outputs to reset values. Buffered bytes are discarded and the packet is truncated without Tlast.
- Tlast: asserted on exactly one beat per packet. Exactly len beats are issued per start, with no duplicates or drops.

Test Plan:
- Basic packet: write A1,A2,A3; start; T_ready=1 -> valid on cycles start+1..start+3 with data A1,A2,A3; Tlast only with A3; done pulse on start+4; busy low and byte_count=0 afterwards.
- Backpressure: 5-byte packet 10..14; drop T_ready for 4 cycles while beat 11 is presented -> out_data holds 11, valid stays 1, Tlast 0. Resume -> sink receives exactly 10,11,12,13,14 with Tlast on 14.
- Full buffer: write 00..0F then a 17th byte FF -> wr_full=1, byte_count=16, FF dropped. Start -> 16 beats 00..0F, Tlast on 0F only.
- Single-byte packet: write 5A; start -> first beat has out_data=5A with T_valid_out=1 and Tlast=1 together; done the cycle after the handshake.
- Ignored requests:
  - start with empty buffer -> T_valid_out stays 0, no done.
  - During SEND, pulse start and wr_en=1 with wr_data=EE -> packet unchanged, EE never appears, byte_count unchanged.
- Reset mid-packet: 5-byte packet; assert reset after 2 beats accepted -> next cycle T_valid_out=0, Tlast=0, busy=0, byte_count=0. Then load and send B0,B1 -> exactly B0,B1 with Tlast on B1.

Source files
------------

// File: rtl/axis_8_bit_packet_tx.sv
// Byte-buffered AXI-Stream style transmitter: local logic fills a buffer in IDLE,
// a start pulse streams the buffered bytes out as one packet with Tlast on the final beat.
module axis_8_bit_packet_tx #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   output logic             wr_full,
   output logic [CNT_W-1:0] byte_count,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             T_valid_out,
   input  logic             T_ready,
   output logic             Tlast,
   output logic [7:0]       out_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      S_IDLE,
      S_SEND
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_len;
   logic             r_full;
   logic             r_busy;
   logic             r_done;
   logic             r_valid;
   logic             r_last;
   logic [7:0]       r_data;
   logic [7:0]       r_mem [DEPTH];

   logic [CNT_W-1:0] w_wr_ptr_nxt;
   logic [CNT_W-1:0] w_rd_ptr_nxt;
   logic [CNT_W-1:0] w_len_nxt;
   logic [CNT_W-1:0] w_rd_inc;
   logic             w_valid_nxt;
   logic             w_last_nxt;
   logic [7:0]       w_data_nxt;
   logic             w_done_nxt;
   logic             w_launch;
   logic             w_write;

   // A start with an empty buffer is not a launch, so a coincident write still lands.
   assign w_launch = (r_state == S_IDLE) && start && (r_wr_ptr != '0);
   assign w_write  = (r_state == S_IDLE) && wr_en && !r_full && !w_launch;
   assign w_rd_inc = r_rd_ptr + CNT_W'(1);

   // NOTE: the buffer has no reset; stale bytes are unreachable once wr_ptr returns to 0.
   always_ff @(posedge clk) begin
      if (!reset && w_write) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      w_state_nxt  = r_state;
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_len_nxt    = r_len;
      w_valid_nxt  = r_valid;
      w_last_nxt   = r_last;
      w_data_nxt   = r_data;
      w_done_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_launch) begin
               w_state_nxt  = S_SEND;
               w_len_nxt    = r_wr_ptr;
               w_rd_ptr_nxt = '0;
               w_valid_nxt  = 1'b1;
               w_data_nxt   = r_mem[0];
               w_last_nxt   = (r_wr_ptr == CNT_W'(1));
            end else if (w_write) begin
               w_wr_ptr_nxt = r_wr_ptr + CNT_W'(1);
            end
         end
         S_SEND: begin
            if (r_valid && T_ready) begin
               if (r_last) begin
                  w_state_nxt  = S_IDLE;
                  w_valid_nxt  = 1'b0;
                  w_last_nxt   = 1'b0;
                  w_data_nxt   = 8'h00;
                  w_wr_ptr_nxt = '0;
                  w_rd_ptr_nxt = '0;
                  w_done_nxt   = 1'b1;
               end else begin
                  w_rd_ptr_nxt = w_rd_inc;
                  w_data_nxt   = r_mem[w_rd_inc[AW-1:0]];
                  w_last_nxt   = ((r_rd_ptr + CNT_W'(2)) == r_len);
               end
            end
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_len    <= '0;
         r_full   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_data   <= 8'h00;
      end else begin
         r_state  <= w_state_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_len    <= w_len_nxt;
         r_full   <= (w_wr_ptr_nxt == CNT_W'(DEPTH));
         r_busy   <= (w_state_nxt == S_SEND);
         r_done   <= w_done_nxt;
         r_valid  <= w_valid_nxt;
         r_last   <= w_last_nxt;
         r_data   <= w_data_nxt;
      end
   end

   assign wr_full     = r_full;
   assign byte_count  = r_wr_ptr;
   assign busy        = r_busy;
   assign done        = r_done;
   assign T_valid_out = r_valid;
   assign Tlast       = r_last;
   assign out_data    = r_data;

endmodule

// File: tb/tb_axis_8_bit_packet_tx.sv
// Scoreboard bench: tests push expected beats, a negedge monitor pops and compares
// every accepted beat, checks hold-under-backpressure and counts done pulses.
module tb_axis_8_bit_packet_tx;

   localparam int DEPTH = 16;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             wr_full;
   logic [CNT_W-1:0] byte_count;
   logic             start;
   logic             busy;
   logic             done;
   logic             T_valid_out;
   logic             T_ready;
   logic             Tlast;
   logic [7:0]       out_data;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   beat_t exp_q[$];
   int    total    = 0;
   int    bad      = 0;
   int    done_cnt = 0;
   logic  prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic  prev_last;

   axis_8_bit_packet_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .wr_full     (wr_full),
      .byte_count  (byte_count),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .T_valid_out (T_valid_out),
      .T_ready     (T_ready),
      .Tlast       (Tlast),
      .out_data    (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, seen, 1'b1);
   endtask

   // Monitor: pops one expected beat per handshake and enforces stable stalled beats.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", T_valid_out, 1'b1);
            check("hold_data", out_data, prev_data);
            check("hold_last", Tlast, prev_last);
         end
         if (T_valid_out && T_ready) begin
            check("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_data", out_data, e.data);
               check("beat_last", Tlast, e.last);
            end
         end
         if (done) begin
            done_cnt++;
            check("done_queue_empty", exp_q.size(), 0);
         end
         prev_stall = T_valid_out && !T_ready;
         prev_data  = out_data;
         prev_last  = Tlast;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      start   = 1'b0;
      T_ready = 1'b0;
      repeat (3) tick();
      check("rst_valid", T_valid_out, 1'b0);
      check("rst_last", Tlast, 1'b0);
      check("rst_data", out_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_count", byte_count, 0);
      check("rst_full", wr_full, 1'b0);
      reset = 1'b0;
      tick();

      // Basic packet, ready held high before valid appears.
      T_ready = 1'b1;
      write_byte(8'hA1);
      write_byte(8'hA2);
      write_byte(8'hA3);
      check("basic_count", byte_count, 3);
      push(8'hA1, 1'b0);
      push(8'hA2, 1'b0);
      push(8'hA3, 1'b1);
      pulse_start();
      check("basic_first_valid", T_valid_out, 1'b1);
      check("basic_first_data", out_data, 8'hA1);
      check("basic_busy", busy, 1'b1);
      tick();
      tick();
      check("basic_last_beat", {Tlast, out_data}, {1'b1, 8'hA3});
      tick();
      check("basic_done", done, 1'b1);
      check("basic_busy_low", busy, 1'b0);
      check("basic_count_zero", byte_count, 0);
      check("basic_valid_low", T_valid_out, 1'b0);
      tick();
      check("basic_done_once", done, 1'b0);

      // Backpressure while beat 11 is presented.
      for (int i = 0; i < 5; i++) begin
         write_byte(8'h10 + 8'(i));
         push(8'h10 + 8'(i), i == 4);
      end
      pulse_start();
      tick();
      T_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_data", out_data, 8'h11);
         check("bp_valid", T_valid_out, 1'b1);
         check("bp_last", Tlast, 1'b0);
      end
      T_ready = 1'b1;
      wait_done("bp_done", 20);

      // Full buffer: 17th byte must be dropped.
      for (int i = 0; i < DEPTH; i++) begin
         write_byte(8'(i));
         push(8'(i), i == DEPTH - 1);
      end
      write_byte(8'hFF);
      check("full_flag", wr_full, 1'b1);
      check("full_count", byte_count, 16);
      pulse_start();
      wait_done("full_done", 40);
      check("full_flag_clear", wr_full, 1'b0);

      // Single-byte packet.
      write_byte(8'h5A);
      push(8'h5A, 1'b1);
      pulse_start();
      check("single_beat", {T_valid_out, Tlast, out_data}, {1'b1, 1'b1, 8'h5A});
      tick();
      check("single_done", done, 1'b1);

      // Start with an empty buffer is ignored.
      tick();
      check("empty_count", byte_count, 0);
      pulse_start();
      check("empty_valid", T_valid_out, 1'b0);
      check("empty_busy", busy, 1'b0);
      tick();
      check("empty_no_done", done, 1'b0);

      // start/wr_en during SEND are ignored.
      write_byte(8'h21);
      write_byte(8'h22);
      write_byte(8'h23);
      push(8'h21, 1'b0);
      push(8'h22, 1'b0);
      push(8'h23, 1'b1);
      T_ready = 1'b0;
      pulse_start();
      start   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      tick();
      start   = 1'b0;
      wr_en   = 1'b0;
      check("ign_count", byte_count, 3);
      check("ign_data", out_data, 8'h21);
      T_ready = 1'b1;
      wait_done("ign_done", 20);

      // Reset mid-packet after two accepted beats.
      for (int i = 0; i < 5; i++) begin
         write_byte(8'h30 + 8'(i));
      end
      push(8'h30, 1'b0);
      push(8'h31, 1'b0);
      pulse_start();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_beats_taken", exp_q.size(), 0);
      exp_q.delete();
      check("mid_rst_valid", T_valid_out, 1'b0);
      check("mid_rst_last", Tlast, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_count", byte_count, 0);
      check("mid_rst_data", out_data, 8'h00);
      write_byte(8'hB0);
      write_byte(8'hB1);
      push(8'hB0, 1'b0);
      push(8'hB1, 1'b1);
      pulse_start();
      wait_done("post_rst_done", 20);

      tick();
      check("end_queue_empty", exp_q.size(), 0);
      check("end_done_count", done_cnt, 6);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
